i2c_slave_ctrl: RTL and testbench

- Controller that sequences the I2C slave PHY's 32-bit word datapath.
- Owns the slave address register and an RX FIFO that drains PHY pushes to a consumer.
- Owns a TX FIFO fed by two requesters through a round-robin arbiter; the PHY pops this FIFO.
- Keeps saturating transaction/error statistics and a maskable sticky interrupt. Sits between i2c_phy and the MCU bus/MM logic.

---
 rtl/i2c_slave_ctrl_if.sv | 41 ++++
 rtl/i2c_slave_ctrl.sv | 101 ++++++++++
 tb/tb_i2c_slave_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_ctrl_if.sv
// i2c_slave_ctrl_if: config, PHY, RX consumer, TX requester and status signals of the slave controller
interface i2c_slave_ctrl_if;
  logic        cfg_addr_we;
  logic [6:0]  cfg_addr;
  logic [2:0]  cfg_irq_en;
  logic        cfg_clr;
  logic [6:0]  reg_addr;
  logic        phy_full;
  logic        phy_push;
  logic [31:0] phy_dout;
  logic        phy_empty;
  logic        phy_pop;
  logic [31:0] phy_din;
  logic        phy_wstop;
  logic        phy_rstop;
  logic        phy_rerr;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        rx_ready;
  logic [1:0]  tx_req;
  logic [31:0] tx_data0;
  logic [31:0] tx_data1;
  logic [1:0]  tx_gnt;
  logic [15:0] stat_wcnt;
  logic [15:0] stat_rcnt;
  logic [15:0] stat_ecnt;
  logic [2:0]  sticky;
  logic        irq;
  modport slave (
    input  cfg_addr_we, cfg_addr, cfg_irq_en, cfg_clr, phy_push, phy_dout, phy_pop,
           phy_wstop, phy_rstop, phy_rerr, rx_ready, tx_req, tx_data0, tx_data1,
    output reg_addr, phy_full, phy_empty, phy_din, rx_valid, rx_data, tx_gnt,
           stat_wcnt, stat_rcnt, stat_ecnt, sticky, irq
  );
  modport master (
    output cfg_addr_we, cfg_addr, cfg_irq_en, cfg_clr, phy_push, phy_dout, phy_pop,
           phy_wstop, phy_rstop, phy_rerr, rx_ready, tx_req, tx_data0, tx_data1,
    input  reg_addr, phy_full, phy_empty, phy_din, rx_valid, rx_data, tx_gnt,
           stat_wcnt, stat_rcnt, stat_ecnt, sticky, irq
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// i2c_slave_ctrl: address register, RX/TX word FIFOs, round-robin TX arbiter, stats and sticky irq for the I2C slave PHY
module i2c_slave_ctrl #(
  parameter int         RX_AW           = 4,
  parameter int         TX_AW           = 4,
  parameter int         RX_HEADROOM     = 2,
  parameter logic [6:0] DEF_ADDR        = 7'h3b,
  parameter bit         TX_FLUSH_ON_ERR = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  i2c_slave_ctrl_if.slave bus
);
  localparam int RXN = 2 ** RX_AW;
  localparam int TXN = 2 ** TX_AW;
  localparam logic [RX_AW:0] RX_D  = (RX_AW + 1)'(RXN);
  localparam logic [RX_AW:0] RX_HR = (RX_AW + 1)'(RX_HEADROOM);
  localparam logic [TX_AW:0] TX_D  = (TX_AW + 1)'(TXN);
  typedef enum logic {IDLE, GRANT} arb_e;
  logic [31:0]      rx_mem [RXN];
  logic [RX_AW-1:0] rx_wp, rx_rp;
  logic [RX_AW:0]   rx_cnt;
  logic             rx_pop, rx_full, rx_wr, ovf;
  logic [31:0]      tx_mem [TXN];
  logic [TX_AW-1:0] tx_wp, tx_rp;
  logic [TX_AW:0]   tx_cnt;
  logic             tx_full, tx_nempty, tx_pop, tx_wr, udf, flush;
  arb_e             arb_st;
  logic             ptr, pick;
  assign rx_pop        = bus.rx_valid & bus.rx_ready;
  assign rx_full       = rx_cnt == RX_D;
  assign rx_wr         = bus.phy_push & (~rx_full | rx_pop);
  assign ovf           = bus.phy_push & rx_full & ~rx_pop;
  assign bus.rx_valid  = rx_cnt != '0;
  assign bus.rx_data   = rx_mem[rx_rp];
  assign bus.phy_full  = (RX_D - rx_cnt) < RX_HR;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_wr) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + (RX_AW + 1)'(rx_wr) - (RX_AW + 1)'(rx_pop);
    end
  always_ff @(posedge clk)
    if (rx_wr) rx_mem[rx_wp] <= bus.phy_dout;
  assign tx_full       = tx_cnt == TX_D;
  assign tx_nempty     = tx_cnt != '0;
  assign flush         = TX_FLUSH_ON_ERR & bus.phy_rerr;
  assign udf           = bus.phy_pop & ~tx_nempty;
  assign tx_pop        = bus.phy_pop & tx_nempty & ~flush;
  assign tx_wr         = arb_st == GRANT;
  assign bus.phy_empty = ~tx_nempty;
  assign bus.phy_din   = tx_nempty ? tx_mem[tx_rp] : '0;
  // Grant decision is made fresh every cycle; only the round-robin pointer is stored
  always_comb begin
    arb_st     = (|bus.tx_req && !tx_full && !bus.phy_rerr) ? GRANT : IDLE;
    pick       = &bus.tx_req ? ptr : bus.tx_req[1];
    bus.tx_gnt = arb_st == GRANT ? (pick ? 2'b10 : 2'b01) : 2'b00;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr    <= 1'b0;
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (arb_st == GRANT) ptr <= ~pick;
      if (flush) begin
        tx_wp  <= '0;
        tx_rp  <= '0;
        tx_cnt <= '0;
      end else begin
        if (tx_wr) tx_wp <= tx_wp + 1'b1;
        if (tx_pop) tx_rp <= tx_rp + 1'b1;
        tx_cnt <= tx_cnt + (TX_AW + 1)'(tx_wr) - (TX_AW + 1)'(tx_pop);
      end
    end
  always_ff @(posedge clk)
    if (tx_wr) tx_mem[tx_wp] <= pick ? bus.tx_data1 : bus.tx_data0;
  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic inc);
    return (inc && c != 16'hffff) ? c + 16'd1 : c;
  endfunction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.reg_addr  <= DEF_ADDR;
      bus.stat_wcnt <= '0;
      bus.stat_rcnt <= '0;
      bus.stat_ecnt <= '0;
      bus.sticky    <= '0;
      bus.irq       <= 1'b0;
    end else begin
      if (bus.cfg_addr_we) bus.reg_addr <= bus.cfg_addr;
      bus.stat_wcnt <= bus.cfg_clr ? '0 : sat_inc(bus.stat_wcnt, bus.phy_wstop);
      bus.stat_rcnt <= bus.cfg_clr ? '0 : sat_inc(bus.stat_rcnt, bus.phy_rstop);
      bus.stat_ecnt <= bus.cfg_clr ? '0 : sat_inc(bus.stat_ecnt, bus.phy_rerr);
      bus.sticky    <= bus.cfg_clr ? '0 : bus.sticky | {udf, ovf, bus.phy_rerr};
      bus.irq       <= |(bus.sticky & bus.cfg_irq_en);
    end
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb_i2c_slave_ctrl: directed stimulus with RX/TX scoreboards popped by a negedge monitor
module tb_i2c_slave_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  i2c_slave_ctrl_if bus();
  i2c_slave_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic [31:0] rxq[$];
  logic [31:0] txq[$];
  logic [1:0]  gnt_exp [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [31:0] tx_exp  [4] = '{32'ha0000000, 32'hb0000001, 32'ha0000002, 32'hb0000003};
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_vals(input string n);
    chk({n, "_addr"}, 32'(bus.reg_addr), 32'h3b);
    chk({n, "_empty"}, 32'(bus.phy_empty), 32'd1);
    chk({n, "_full"}, 32'(bus.phy_full), 32'd0);
    chk({n, "_rxv"}, 32'(bus.rx_valid), 32'd0);
    chk({n, "_gnt"}, 32'(bus.tx_gnt), 32'd0);
    chk({n, "_din"}, bus.phy_din, 32'd0);
    chk({n, "_wcnt"}, 32'(bus.stat_wcnt), 32'd0);
    chk({n, "_rcnt"}, 32'(bus.stat_rcnt), 32'd0);
    chk({n, "_ecnt"}, 32'(bus.stat_ecnt), 32'd0);
    chk({n, "_sticky"}, 32'(bus.sticky), 32'd0);
    chk({n, "_irq"}, 32'(bus.irq), 32'd0);
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (bus.rx_valid && bus.rx_ready) begin
        if (rxq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_extra: got %0h expected no word", bus.rx_data);
        end else chk("rx_data", bus.rx_data, rxq.pop_front());
      end
      if (bus.phy_pop && !bus.phy_empty) begin
        if (txq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_extra: got %0h expected no word", bus.phy_din);
        end else chk("tx_data", bus.phy_din, txq.pop_front());
      end
    end
  initial begin
    bus.cfg_addr_we = 0; bus.cfg_addr = '0; bus.cfg_irq_en = 3'b010; bus.cfg_clr = 0;
    bus.phy_push = 0; bus.phy_dout = '0; bus.phy_pop = 0; bus.phy_wstop = 0;
    bus.phy_rstop = 0; bus.phy_rerr = 0; bus.rx_ready = 0; bus.tx_req = '0;
    bus.tx_data0 = '0; bus.tx_data1 = '0;
    #12;
    chk_reset_vals("rst");
    tick;
    rst_n = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      bus.phy_push = 1; bus.phy_dout = 32'h11111111 * (i + 1); rxq.push_back(bus.phy_dout);
      tick;
    end
    bus.phy_push = 0;
    @(negedge clk);
    chk("rx_valid3", 32'(bus.rx_valid), 32'd1);
    chk("rx_head", bus.rx_data, 32'h11111111);
    tick;
    bus.rx_ready = 1;
    repeat (3) tick;
    bus.rx_ready = 0;
    @(negedge clk);
    chk("rx_drained", 32'(bus.rx_valid), 32'd0);
    tick;
    for (int i = 0; i < 14; i++) begin
      bus.phy_push = 1; bus.phy_dout = 32'hc0000000 + i; rxq.push_back(bus.phy_dout);
      tick;
    end
    bus.phy_push = 0;
    @(negedge clk);
    chk("full_at14", 32'(bus.phy_full), 32'd0);
    tick;
    bus.phy_push = 1; bus.phy_dout = 32'hc000000e; rxq.push_back(bus.phy_dout);
    tick;
    bus.phy_push = 0;
    @(negedge clk);
    chk("full_at15", 32'(bus.phy_full), 32'd1);
    chk("no_ovf_yet", 32'(bus.sticky), 32'd0);
    tick;
    bus.phy_push = 1; bus.phy_dout = 32'hc000000f; rxq.push_back(bus.phy_dout);
    tick;
    bus.phy_dout = 32'hdeadbeef;
    tick;
    bus.phy_push = 0;
    @(negedge clk);
    chk("ovf_sticky", 32'(bus.sticky), 32'b010);
    chk("irq_lat", 32'(bus.irq), 32'd0);
    tick;
    @(negedge clk);
    chk("irq_ovf", 32'(bus.irq), 32'd1);
    tick;
    bus.rx_ready = 1;
    repeat (16) tick;
    bus.rx_ready = 0;
    @(negedge clk);
    chk("rx_empty16", 32'(bus.rx_valid), 32'd0);
    chk("rxq_left", 32'(rxq.size()), 32'd0);
    tick;
    for (int k = 0; k < 4; k++) begin
      bus.tx_req = 2'b11; bus.tx_data0 = 32'ha0000000 + k; bus.tx_data1 = 32'hb0000000 + k;
      @(negedge clk);
      chk("rr_gnt", 32'(bus.tx_gnt), 32'(gnt_exp[k]));
      txq.push_back(tx_exp[k]);
      tick;
    end
    bus.tx_req = '0;
    bus.phy_pop = 1;
    repeat (4) tick;
    bus.phy_pop = 0;
    @(negedge clk);
    chk("tx_empty4", 32'(bus.phy_empty), 32'd1);
    chk("txq_left", 32'(txq.size()), 32'd0);
    tick;
    for (int k = 0; k < 5; k++) begin
      bus.tx_req = 2'b01; bus.tx_data0 = 32'h55550000 + k;
      @(negedge clk);
      chk("single_gnt", 32'(bus.tx_gnt), 32'b01);
      tick;
    end
    bus.phy_rerr = 1;
    @(negedge clk);
    chk("rerr_gnt", 32'(bus.tx_gnt), 32'd0);
    chk("pre_flush", 32'(bus.phy_empty), 32'd0);
    tick;
    bus.phy_rerr = 0; bus.tx_req = '0;
    @(negedge clk);
    chk("flush_empty", 32'(bus.phy_empty), 32'd1);
    chk("ecnt", 32'(bus.stat_ecnt), 32'd1);
    chk("err_sticky", 32'(bus.sticky), 32'b011);
    tick;
    bus.phy_pop = 1;
    @(negedge clk);
    chk("udf_din", bus.phy_din, 32'd0);
    tick;
    bus.phy_pop = 0;
    @(negedge clk);
    chk("udf_sticky", 32'(bus.sticky), 32'b111);
    tick;
    bus.phy_wstop = 1;
    tick;
    tick;
    bus.phy_wstop = 0;
    @(negedge clk);
    chk("wcnt2", 32'(bus.stat_wcnt), 32'd2);
    tick;
    bus.cfg_clr = 1; bus.phy_wstop = 1;
    tick;
    bus.cfg_clr = 0; bus.phy_wstop = 0;
    @(negedge clk);
    chk("clr_wcnt", 32'(bus.stat_wcnt), 32'd0);
    chk("clr_ecnt", 32'(bus.stat_ecnt), 32'd0);
    chk("clr_sticky", 32'(bus.sticky), 32'd0);
    tick;
    @(negedge clk);
    chk("clr_irq", 32'(bus.irq), 32'd0);
    tick;
    bus.phy_rstop = 1;
    repeat (5) tick;
    bus.phy_rstop = 0;
    @(negedge clk);
    chk("rcnt5", 32'(bus.stat_rcnt), 32'd5);
    tick;
    bus.phy_rstop = 1;
    repeat (65535) tick;
    bus.phy_rstop = 0;
    @(negedge clk);
    chk("rcnt_sat", 32'(bus.stat_rcnt), 32'hffff);
    tick;
    bus.cfg_addr_we = 1; bus.cfg_addr = 7'h55;
    @(negedge clk);
    chk("addr_hold", 32'(bus.reg_addr), 32'h3b);
    tick;
    bus.cfg_addr_we = 0;
    @(negedge clk);
    chk("addr_load", 32'(bus.reg_addr), 32'h55);
    tick;
    bus.phy_push = 1; bus.phy_dout = 32'h77777777; bus.tx_req = 2'b01; bus.phy_wstop = 1;
    bus.cfg_irq_en = 3'b111;
    tick;
    bus.phy_push = 0; bus.phy_wstop = 0; bus.phy_rerr = 1; bus.tx_req = '0;
    tick;
    bus.phy_rerr = 0; bus.tx_req = 2'b01;
    tick;
    bus.tx_req = '0; bus.phy_rstop = 1;
    @(negedge clk);
    chk("pre_rst_rxv", 32'(bus.rx_valid), 32'd1);
    chk("pre_rst_empty", 32'(bus.phy_empty), 32'd0);
    chk("pre_rst_wcnt", 32'(bus.stat_wcnt), 32'd1);
    chk("pre_rst_irq", 32'(bus.irq), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    bus.phy_rstop = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
